// File: rtl/sti_seq_ctrl_pkg.sv
// sti_ctrl_pkg: shared types and helpers for the STI sequencer.
package sti_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, SHIFT} state_t;
    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_24 = 2'b10;
    localparam logic [1:0] LEN_32 = 2'b11;
    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  length;
        logic        fill;
        logic        msb;
        logic        low;
        logic        last;
    } cmd_t;
    function automatic logic [5:0] nbits(input logic [1:0] len);
        return {1'b0, len, 3'b000} + 6'd8;
    endfunction
endpackage

// File: rtl/sti_seq_ctrl_if.sv
// sti_seq_ctrl_if: valid/ready command channel from the requester to the sequencer.
interface sti_seq_ctrl_if;
    logic        valid;
    logic        ready;
    logic [15:0] data;
    logic [1:0]  length;
    logic        fill;
    logic        msb;
    logic        low;
    logic        last;
    modport master (output valid, data, length, fill, msb, low, last, input ready);
    modport slave  (input valid, data, length, fill, msb, low, last, output ready);
endinterface

// File: rtl/sti_seq_ctrl_fifo.sv
// sti_cmd_fifo: synchronous command FIFO, extra pointer MSB distinguishes full from empty.
module sti_cmd_fifo
    import sti_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  cmd_t din,
    output cmd_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    cmd_t        mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/sti_seq_ctrl.sv
// sti_seq_ctrl: buffers words and paces load strobes into the STI serializer.
// STI_SEQ_CHK_EN adds a sticky proto_err output checking so_valid against the FSM.
module sti_seq_ctrl
    import sti_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sti_seq_ctrl_if.slave cmd,
    output logic          load,
    output logic [15:0]   pi_data,
    output logic [1:0]    pi_length,
    output logic          pi_fill,
    output logic          pi_msb,
    output logic          pi_low,
    output logic          pi_end,
    input  logic          so_valid,
    output logic          busy,
    output logic          done
`ifdef STI_SEQ_CHK_EN
    ,
    output logic          proto_err
`endif
);
    state_t     state, nxt;
    cmd_t       din, head, hold;
    logic       full, empty, push, pop, last_in, end_seen, shift_end;
    logic [5:0] bitcnt;
    assign cmd.ready = !full && !pi_end;
    // Once the final word has been accepted, later handshakes complete but are discarded.
    assign push      = cmd.valid && cmd.ready && !last_in;
    assign shift_end = state == SHIFT && bitcnt == 6'd0;
    assign pop       = !empty && !pi_end && (state == IDLE || shift_end);
    assign din       = '{data: cmd.data, length: cmd.length, fill: cmd.fill,
                         msb: cmd.msb, low: cmd.low, last: cmd.last};
    sti_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end
    always_comb begin
        nxt = pop                               ? LOAD  :
              state == LOAD                     ? WAIT  :
              state == WAIT                     ? SHIFT :
              (state == SHIFT && !shift_end)    ? SHIFT : IDLE;
    end
    always_comb begin
        load = state == LOAD;
        busy = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold     <= '0;
            bitcnt   <= '0;
            last_in  <= 1'b0;
            end_seen <= 1'b0;
            pi_end   <= 1'b0;
        end else begin
            if (pop) hold <= head;
            if (state == WAIT)       bitcnt <= nbits(hold.length) - 6'd1;
            else if (state == SHIFT) bitcnt <= bitcnt - 6'd1;
            if (cmd.valid && cmd.ready && cmd.last) last_in <= 1'b1;
            if (shift_end && hold.last) end_seen <= 1'b1;
            if (state == IDLE && end_seen && empty) pi_end <= 1'b1;
        end
    end
    assign pi_data   = hold.data;
    assign pi_length = hold.length;
    assign pi_fill   = hold.fill;
    assign pi_msb    = hold.msb;
    assign pi_low    = hold.low;
    assign done      = pi_end;
`ifdef STI_SEQ_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) proto_err <= 1'b0;
        else if ((state == SHIFT && !so_valid) || (state != SHIFT && so_valid && !pi_end))
            proto_err <= 1'b1;
    end
`else
    logic so_valid_unused;
    assign so_valid_unused = so_valid;
`endif
endmodule

// File: tb/tb_sti_seq_ctrl.sv
// tb_sti_seq_ctrl: directed stimulus with a load-driven scoreboard monitor for sti_seq_ctrl.
module tb_sti_seq_ctrl;
    import sti_ctrl_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    sti_seq_ctrl_if cif();
    logic        load, pi_fill, pi_msb, pi_low, pi_end, busy, done;
    logic        so_valid = 1'b0;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
`ifdef STI_SEQ_CHK_EN
    logic        proto_err;
`endif
    sti_seq_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cif),
        .load      (load),
        .pi_data   (pi_data),
        .pi_length (pi_length),
        .pi_fill   (pi_fill),
        .pi_msb    (pi_msb),
        .pi_low    (pi_low),
        .pi_end    (pi_end),
        .so_valid  (so_valid),
        .busy      (busy),
        .done      (done)
`ifdef STI_SEQ_CHK_EN
        ,
        .proto_err (proto_err)
`endif
    );
    int   checks = 0;
    int   failures = 0;
    int   idle_ends = 0;
    cmd_t exp_q[$];
    bit   corrupt = 1'b0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask
    // Scoreboard monitor: every load pops one expected word, then tracks its window.
    cmd_t cur;
    int   cnt = 0;
    bit   active = 1'b0;
    bit   stable = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) active = 1'b0;
        else begin
            if (active && (load || !busy)) begin
                chk("window_len", cnt, 2 + nbits(cur.length));
                chk("pi_stable", {31'd0, stable}, 1);
                if (!busy) idle_ends++;
                active = 1'b0;
            end
            if (load) begin
                if (exp_q.size() == 0) chk("unexpected_load", 1, 0);
                else begin
                    cur = exp_q.pop_front();
                    chk("pi_word", {pi_data, pi_length, pi_fill, pi_msb, pi_low},
                        {cur.data, cur.length, cur.fill, cur.msb, cur.low});
                    active = 1'b1;
                    cnt = 1;
                    stable = 1'b1;
                end
            end else if (active) begin
                cnt++;
                if ({pi_data, pi_length, pi_fill, pi_msb, pi_low} !==
                    {cur.data, cur.length, cur.fill, cur.msb, cur.low}) stable = 1'b0;
            end
        end
    end
    // STI stand-in: so_valid high for the N shift cycles following LOAD and WAIT.
    int k = 100;
    int n = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            k = 100;
            so_valid = 1'b0;
        end else begin
            if (load) begin
                k = 0;
                n = int'(nbits(pi_length));
            end else if (k < 100) k++;
            so_valid = k >= 2 && k < 2 + n && !(corrupt && k == 4);
        end
    end
    task automatic send(input logic [15:0] d, input logic [1:0] len, input logic f, m, lo, la,
                        input bit expect_load);
        cif.valid = 1'b1;
        cif.data = d;
        cif.length = len;
        cif.fill = f;
        cif.msb = m;
        cif.low = lo;
        cif.last = la;
        for (int t = 0; t < 200 && !cif.ready; t++) @(negedge clk);
        if (!cif.ready) chk("send_timeout", 0, 1);
        else if (expect_load)
            exp_q.push_back('{data: d, length: len, fill: f, msb: m, low: lo, last: la});
        @(negedge clk);
        cif.valid = 1'b0;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        corrupt = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask
    task automatic wait_load();
        for (int t = 0; t < 50 && !load; t++) @(negedge clk);
        chk("load_seen", {31'd0, load}, 1);
    endtask
    task automatic wait_end();
        for (int t = 0; t < 400 && !pi_end; t++) @(negedge clk);
        chk("pi_end_seen", {31'd0, pi_end}, 1);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end
    initial begin
        cif.valid = 1'b0;
        cif.data = '0;
        cif.length = '0;
        cif.fill = 1'b0;
        cif.msb = 1'b0;
        cif.low = 1'b0;
        cif.last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {load, busy, pi_end, done, pi_data, pi_length, pi_fill, pi_msb, pi_low}, 0);
        chk("rst_ready", {31'd0, cif.ready}, 1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        // single 8-bit final word
        send(16'hA5C3, LEN_8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_load();
        repeat (9) @(negedge clk);
        chk("t1_last_shift_busy", {31'd0, busy}, 1);
        @(negedge clk);
        chk("t1_idle_no_end", {busy, pi_end}, 0);
        @(negedge clk);
        chk("t1_end", {pi_end, done, cif.ready}, 3'b110);
        // four lengths back-to-back
        do_reset();
        idle_ends = 0;
        send(16'h1234, LEN_8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h5678, LEN_16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(16'h9ABC, LEN_24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'hDEF0, LEN_32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 300 && (busy || exp_q.size() != 0); t++) @(negedge clk);
        @(negedge clk);
        chk("t2_drained", {busy, 31'(exp_q.size())}, 0);
        chk("t2_single_idle_gap", idle_ends, 1);
        chk("t2_no_end", {pi_end, cif.ready}, 2'b01);
`ifdef STI_SEQ_CHK_EN
        chk("t2_no_proto_err", {31'd0, proto_err}, 0);
`endif
        // overflow the 4-entry buffer while a 32-bit word shifts
        do_reset();
        send(16'h0F0F, LEN_32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(16'h1111, LEN_8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(16'h2222, LEN_16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(16'h3333, LEN_24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h4444, LEN_8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_full_ready", {31'd0, cif.ready}, 0);
        send(16'h5555, LEN_16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_end();
        chk("t3_all_loaded", exp_q.size(), 0);
        // word after the final one is dropped
        do_reset();
        send(16'hC001, LEN_16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        send(16'hBAD0, LEN_24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_end();
        repeat (5) @(negedge clk);
        chk("t4_end_state", {pi_end, done, cif.ready, load, busy}, 5'b11000);
        // reset in the middle of a 32-bit shift
        do_reset();
        send(16'h7E57, LEN_32, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_load();
        repeat (11) @(negedge clk);
        chk("t5_mid_shift_busy", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1 chk("t5_async_zero", {load, busy, pi_end, done, pi_data, pi_length, pi_fill, pi_msb, pi_low}, 0);
        chk("t5_async_ready", {31'd0, cif.ready}, 1);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_stays_idle", {busy, load}, 0);
        send(16'h0001, LEN_8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_end();
`ifdef STI_SEQ_CHK_EN
        do_reset();
        corrupt = 1'b1;
        chk("t6_err_reset", {31'd0, proto_err}, 0);
        send(16'h00FF, LEN_16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_load();
        chk("t6_err_before", {31'd0, proto_err}, 0);
        wait_end();
        repeat (3) @(negedge clk);
        chk("t6_err_sticky", {31'd0, proto_err}, 1);
`endif
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
